// File: rtl/register_window_ctrl.sv
// Register window controller: CWP/WIM tracking, window traps and
// registered write-enable decode for the global block and windowed bank.
module register_window_ctrl #(
    parameter int NWIN = 8
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        save,
    input  logic        restore,
    input  logic        cwp_load,
    input  logic [2:0]  cwp_in,
    input  logic        wim_load,
    input  logic [7:0]  wim_in,
    input  logic        trap_ack,
    input  logic        wr_req,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [2:0]  cwp,
    output logic [7:0]  wim,
    output logic        trap_ovf,
    output logic        trap_unf,
    output logic        BE,
    output logic [7:0]  RE,
    output logic        win_we,
    output logic [6:0]  win_addr,
    output logic [31:0] wdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] TRAP = 1'b1;

    localparam logic [2:0] LAST     = 3'(NWIN - 1);
    localparam logic [7:0] WIM_MASK = 8'((32'd1 << NWIN) - 32'd1);
    localparam logic [7:0] BANK     = 8'(NWIN * 16);

    logic [0:0] state;
    logic [2:0] cwp_dec;
    logic [2:0] cwp_inc;
    logic [2:0] cwp_mod;
    logic       do_save;
    logic       do_rest;
    logic [7:0] win_sum;
    logic [7:0] win_wrap;

    // Neighbour windows, forced CWP and physical bank index
    always_comb begin
        cwp_dec  = (cwp == 3'd0) ? LAST : cwp - 3'd1;
        cwp_inc  = (cwp == LAST) ? 3'd0 : cwp + 3'd1;
        cwp_mod  = 3'(32'(cwp_in) % 32'(NWIN));
        do_save  = save & ~restore;
        do_rest  = restore & ~save;
        win_sum  = {1'b0, cwp, 4'b0000} + {3'b000, wr_addr} - 8'd8;
        win_wrap = (win_sum >= BANK) ? win_sum - BANK : win_sum;
    end

    // Window FSM: CWP moves, trap raise and acknowledge
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state    <= IDLE;
            cwp      <= 3'd0;
            trap_ovf <= 1'b0;
            trap_unf <= 1'b0;
        end else begin
            if (cwp_load)
                cwp <= cwp_mod;
            case (state)
                IDLE: begin
                    if (!cwp_load && do_save) begin
                        if (wim[cwp_dec]) begin
                            trap_ovf <= 1'b1;
                            state    <= TRAP;
                        end else begin
                            cwp <= cwp_dec;
                        end
                    end else if (!cwp_load && do_rest) begin
                        if (wim[cwp_inc]) begin
                            trap_unf <= 1'b1;
                            state    <= TRAP;
                        end else begin
                            cwp <= cwp_inc;
                        end
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        state    <= IDLE;
                        trap_ovf <= 1'b0;
                        trap_unf <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window invalid mask; bits beyond the implemented windows stay 0
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)
            wim <= 8'd0;
        else if (wim_load)
            wim <= wim_in & WIM_MASK;
    end

    // Registered write decode using the pre-update CWP
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            BE       <= 1'b0;
            RE       <= 8'd0;
            win_we   <= 1'b0;
            win_addr <= 7'd0;
            wdata    <= 32'd0;
        end else begin
            BE     <= 1'b0;
            RE     <= 8'd0;
            win_we <= 1'b0;
            if (wr_req) begin
                wdata <= wr_data;
                if (wr_addr[4:3] != 2'b00) begin
                    win_we   <= 1'b1;
                    win_addr <= win_wrap[6:0];
                end else if (wr_addr[2:0] != 3'd0) begin
                    BE <= 1'b1;
                    RE <= 8'd1 << wr_addr[2:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_window_ctrl.sv
// Randomized and directed bench for register_window_ctrl against an
// arithmetic reference model of the window rules.
module tb_register_window_ctrl;

    localparam int NWIN = 8;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        save, restore, cwp_load, wim_load, trap_ack, wr_req;
    logic [2:0]  cwp_in;
    logic [7:0]  wim_in;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  cwp;
    logic [7:0]  wim;
    logic        trap_ovf, trap_unf, BE, win_we;
    logic [7:0]  RE;
    logic [6:0]  win_addr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    int m_cwp, m_wim, m_trap, m_be, m_re, m_we, m_waddr;
    logic [31:0] m_wdata;

    always #5 Clk = ~Clk;

    register_window_ctrl #(.NWIN(NWIN)) dut (
        .Clk(Clk), .Clr(Clr), .save(save), .restore(restore),
        .cwp_load(cwp_load), .cwp_in(cwp_in),
        .wim_load(wim_load), .wim_in(wim_in), .trap_ack(trap_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .cwp(cwp), .wim(wim), .trap_ovf(trap_ovf), .trap_unf(trap_unf),
        .BE(BE), .RE(RE), .win_we(win_we), .win_addr(win_addr),
        .wdata(wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cwp = 0; m_wim = 0; m_trap = 0;
        m_be = 0; m_re = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic model_step();
        int old_cwp, old_wim, n, dir;
        old_cwp = m_cwp;
        old_wim = m_wim;
        m_be = 0; m_re = 0; m_we = 0;
        if (wr_req) begin
            m_wdata = wr_data;
            if (wr_addr >= 8) begin
                m_we = 1;
                m_waddr = (old_cwp * 16 + int'(wr_addr) - 8) % (NWIN * 16);
            end else if (wr_addr != 0) begin
                m_be = 1;
                m_re = 1 << wr_addr;
            end
        end
        if (m_trap != 0) begin
            if (trap_ack) m_trap = 0;
        end else if (!cwp_load && (save != restore)) begin
            dir = save ? -1 : 1;
            n = (old_cwp + dir + NWIN) % NWIN;
            if ((old_wim >> n) & 1) m_trap = save ? 1 : 2;
            else m_cwp = n;
        end
        if (cwp_load) m_cwp = int'(cwp_in) % NWIN;
        if (wim_load) m_wim = int'(wim_in) & ((1 << NWIN) - 1);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".cwp"}, 32'(cwp), 32'(m_cwp));
        chk({tag, ".wim"}, 32'(wim), 32'(m_wim));
        chk({tag, ".ovf"}, 32'(trap_ovf), 32'(m_trap == 1));
        chk({tag, ".unf"}, 32'(trap_unf), 32'(m_trap == 2));
        chk({tag, ".BE"}, 32'(BE), 32'(m_be));
        chk({tag, ".RE"}, 32'(RE), 32'(m_re));
        chk({tag, ".win_we"}, 32'(win_we), 32'(m_we));
        chk({tag, ".wdata"}, wdata, m_wdata);
        if (m_we != 0) chk({tag, ".win_addr"}, 32'(win_addr), 32'(m_waddr));
    endtask

    task automatic idle_in();
        save = 0; restore = 0; cwp_load = 0; cwp_in = 0;
        wim_load = 0; wim_in = 0; trap_ack = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0;
    endtask

    task automatic cyc(input string tag);
        @(posedge Clk);
        model_step();
        #1 compare_all(tag);
        @(negedge Clk);
        idle_in();
    endtask

    task automatic setup(input int c, input int w);
        cwp_load = 1; cwp_in = 3'(c);
        wim_load = 1; wim_in = 8'(w);
        cyc("setup");
    endtask

    initial begin
        idle_in();
        model_reset();
        Clr = 1;
        #12;
        compare_all("reset");
        chk("reset.win_addr", 32'(win_addr), 32'd0);
        @(negedge Clk);
        Clr = 0;

        // basic save/restore with an empty WIM
        wim_load = 1; wim_in = 8'h00; cyc("wim0");
        save = 1; cyc("save1"); chk("save1.k", 32'(cwp), 32'd7);
        save = 1; cyc("save2"); chk("save2.k", 32'(cwp), 32'd6);
        save = 1; cyc("save3"); chk("save3.k", 32'(cwp), 32'd5);
        restore = 1; cyc("rest1"); chk("rest1.k", 32'(cwp), 32'd6);

        // overflow trap
        setup(0, 8'h80);
        save = 1; cyc("ovf"); chk("ovf.k", 32'(trap_ovf), 32'd1);
        save = 1; cyc("ovf_ign"); chk("ovf_ign.k", 32'(cwp), 32'd0);
        trap_ack = 1; cyc("ovf_ack"); chk("ovf_ack.k", 32'(trap_ovf), 32'd0);

        // underflow trap with CWP forced inside the handler
        setup(7, 8'h01);
        restore = 1; cyc("unf"); chk("unf.k", 32'(trap_unf), 32'd1);
        cwp_load = 1; cwp_in = 3; cyc("unf_ld");
        chk("unf_ld.k", 32'(cwp), 32'd3);
        chk("unf_ld.f", 32'(trap_unf), 32'd1);
        trap_ack = 1; cyc("unf_ack");

        // write decode
        setup(2, 8'h00);
        wr_req = 1; wr_addr = 9; wr_data = 32'hDEADBEEF; cyc("wr9");
        chk("wr9.addr", 32'(win_addr), 32'd33);
        chk("wr9.data", wdata, 32'hDEADBEEF);
        wr_req = 1; wr_addr = 5; wr_data = 32'h12345678; cyc("wr5");
        chk("wr5.RE", 32'(RE), 32'h20);
        wr_req = 1; wr_addr = 0; wr_data = 32'h1; cyc("wr0");
        cyc("wr_none");

        // bank wrap and simultaneous save/restore
        setup(7, 8'h00);
        wr_req = 1; wr_addr = 31; wr_data = 32'hA5A5A5A5; cyc("wr31");
        chk("wr31.addr", 32'(win_addr), 32'd7);
        save = 1; restore = 1; cyc("both"); chk("both.k", 32'(cwp), 32'd7);

        // reset between edges while trapped with a write in flight
        setup(0, 8'h80);
        save = 1; cyc("pre_clr");
        wr_req = 1; wr_addr = 3; wr_data = 32'hCAFEF00D;
        @(posedge Clk);
        #3 Clr = 1;
        model_reset();
        #1 compare_all("clr");
        chk("clr.win_addr", 32'(win_addr), 32'd0);
        @(negedge Clk);
        idle_in();
        Clr = 0;
        cyc("post_clr");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            save     = ($urandom_range(0, 2) == 0);
            restore  = ($urandom_range(0, 2) == 0);
            cwp_load = ($urandom_range(0, 15) == 0);
            cwp_in   = 3'($urandom);
            wim_load = ($urandom_range(0, 9) == 0);
            wim_in   = 8'($urandom);
            trap_ack = ($urandom_range(0, 3) == 0);
            wr_req   = ($urandom_range(0, 1) == 0);
            wr_addr  = 5'($urandom);
            wr_data  = $urandom;
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/register_window_ctrl.md
REGISTER_WINDOW_CTRL -- requirements
Module: register_window_ctrl

Interface
REQ-001 SHALL have parameter NWIN, default 8, meaning the number of register windows, legal range 2..8.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Clr, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port save, input, 1, SAVE request; decrements CWP.
REQ-005 SHALL have port restore, input, 1, RESTORE request; increments CWP.
REQ-006 SHALL have ports cwp_load, input, 1 and cwp_in, input, 3, which force CWP (trap handler).
REQ-007 SHALL have ports wim_load, input, 1 and wim_in, input, 8, which write WIM.
REQ-008 SHALL have port trap_ack, input, 1, handler acknowledge of a pending window trap.
REQ-009 SHALL have ports wr_req, input, 1; wr_addr, input, 5 (logical r0-r31); wr_data, input, 32.
REQ-010 SHALL have ports cwp, output, 3 and wim, output, 8, the current state.
REQ-011 SHALL have ports trap_ovf and trap_unf, output, 1 each, level window-overflow/underflow trap.
REQ-012 SHALL have ports BE, output, 1 and RE, output, 8, global-block write enables (active-high, one-hot RE).
REQ-013 SHALL have ports win_we, output, 1 and win_addr, output, 7, windowed-bank write enable and physical index.
REQ-014 SHALL have port wdata, output, 32, registered write data aligned with the enables.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and TRAP.
REQ-016 In IDLE, save alone SHALL compute n=(cwp-1) mod NWIN; if wim[n]=1 assert trap_ovf and go to TRAP with cwp unchanged, else cwp<=n.
REQ-017 In IDLE, restore alone SHALL compute n=(cwp+1) mod NWIN; if wim[n]=1 assert trap_unf and go to TRAP with cwp unchanged, else cwp<=n.
REQ-018 save and restore asserted in the same cycle SHALL be a no-op (no CWP change, no trap).
REQ-019 In TRAP, save and restore SHALL be ignored and the asserted trap flag SHALL hold until trap_ack is sampled; the FSM then returns to IDLE and clears both flags on that edge.
REQ-020 cwp_load SHALL take priority over save/restore in either state: cwp<=cwp_in mod NWIN, no trap generated, FSM state unchanged.
REQ-021 wim_load SHALL update wim on the edge in any state; bits at index >= NWIN SHALL be forced to 0; a save/restore in the same cycle SHALL check the old wim.
REQ-022 Write decode SHALL be a one-cycle registered stage: request sampled at edge k produces enables and wdata valid for exactly the cycle after edge k.
REQ-023 Decode SHALL use the cwp value before any update on the same edge.
REQ-024 wr_addr 1-7 SHALL give BE=1, RE one-hot at bit wr_addr, win_we=0.
REQ-025 wr_addr 0 SHALL produce no enable (r0 is constant zero).
REQ-026 wr_addr 8-31 SHALL give win_we=1, BE=0, RE=0, win_addr=(cwp*16 + wr_addr-8) mod (NWIN*16), 7-bit wrap, so window outs overlap the next window's ins.
REQ-027 Without wr_req, BE, RE, win_we SHALL be 0; wdata SHALL hold its last value.
REQ-028 Writes SHALL be honoured in both FSM states.

Reset
REQ-029 Clr SHALL immediately force cwp=0, wim=0, trap_ovf=0, trap_unf=0, BE=0, RE=0, win_we=0, win_addr=0, wdata=0, FSM=IDLE, independent of Clk.
REQ-030 Clr asserted mid-trap or mid-write SHALL discard the pending trap and write; the first edge after deassertion behaves as from IDLE.

Verification
REQ-031 Reset, wim_load wim_in=0x00, save x3 -> cwp 7,6,5; restore x1 -> cwp 6; no traps.
REQ-032 cwp=0, wim=0x80, save -> trap_ovf=1, cwp=0; further save ignored; trap_ack -> trap_ovf=0 next cycle, IDLE.
REQ-033 cwp=7, wim=0x01, restore -> trap_unf=1, cwp=7; cwp_load cwp_in=3 during TRAP -> cwp=3, trap_unf still 1 until trap_ack.
REQ-034 cwp=2, wr_req wr_addr=9 wr_data=0xDEADBEEF -> next cycle win_we=1, win_addr=33, wdata=0xDEADBEEF; wr_addr=5 -> BE=1, RE=0x20; wr_addr=0 -> no enables.
REQ-035 cwp=7, wr_addr=31 -> win_addr=(112+23) mod 128=7; save and restore together -> cwp unchanged.
REQ-036 Assert Clr between edges during TRAP with pending write -> all outputs 0 immediately, no enables on following edge.
